// File: rtl/run_controller_pkg.sv
// Shared definitions for the run controller: FSM state type, parameter
// defaults and the reset-phase counter sizing helper.
package run_controller_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RST,
        ST_RUN,
        ST_DONE,
        ST_TIMEOUT
    } state_t;

    localparam int unsigned RESET_CYCLES_DEFAULT   = 10;
    localparam int unsigned TIMEOUT_CYCLES_DEFAULT = 1040;
    localparam int unsigned CNT_W_DEFAULT          = 16;

    // Width needed to hold a reset-phase count of 0..reset_cycles.
    function automatic int unsigned rst_cnt_width(input int unsigned reset_cycles);
        return $clog2(reset_cycles + 1);
    endfunction

endpackage

// File: rtl/run_controller_cycle_counter.sv
// Up-counter with synchronous clear (priority over enable) and a
// terminal-count compare against a fixed value.
module cycle_counter
    import run_controller_pkg::*;
#(
    parameter int unsigned     W    = CNT_W_DEFAULT,
    parameter logic [W-1:0]    TERM = '0
) (
    input  logic         i_clk,
    input  logic         i_clr,
    input  logic         i_en,
    output logic [W-1:0] o_count,
    output logic         o_term
);

    logic [W-1:0] r_count;

    // Count register: clear wins over enable.
    always_ff @(posedge i_clk) begin
        if (i_clr) begin
            r_count <= '0;
        end else if (i_en) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_count = r_count;
    assign o_term  = (r_count == TERM);

endmodule

// File: rtl/run_controller.sv
// Run controller: holds the CPU in reset for RESET_CYCLES, releases it,
// counts RUN cycles and ends the run on HALT or on the cycle budget.
module run_controller
    import run_controller_pkg::*;
#(
    parameter int unsigned RESET_CYCLES   = RESET_CYCLES_DEFAULT,
    parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT,
    parameter int unsigned CNT_W          = CNT_W_DEFAULT,
    parameter bit          AUTO_START     = 1'b1,
    parameter bit          HOLD_ON_DONE   = 1'b0
) (
    input  logic             CLOCK,
    input  logic             RESET,
    input  logic             START,
    input  logic             HALT,
    output logic             CPU_RESET,
    output logic             RUNNING,
    output logic             DONE,
    output logic             TIMED_OUT,
    output logic [CNT_W-1:0] CYCLES
);

    localparam int unsigned RST_CNT_W = rst_cnt_width(RESET_CYCLES);

    state_t               r_state;
    logic                 r_cpu_reset;
    logic                 r_running;
    logic                 r_done;
    logic                 r_timed_out;

    logic                 w_enter_rst;
    logic                 w_clr;
    logic                 w_rst_en;
    logic                 w_run_en;
    logic                 w_rst_term;
    logic                 w_run_term;
    logic [RST_CNT_W-1:0] w_unused_rst_count;
    logic [CNT_W-1:0]     w_run_count;

    // Decode the edges that (re)enter the reset phase and the counter enables.
    always_comb begin
        w_enter_rst = 1'b0;
        if (!RESET) begin
            case (r_state)
                ST_IDLE:               w_enter_rst = AUTO_START || START;
                ST_DONE, ST_TIMEOUT:   w_enter_rst = START;
                default:               w_enter_rst = 1'b0;
            endcase
        end
        w_clr    = RESET || w_enter_rst;
        w_rst_en = (r_state == ST_RST);
        w_run_en = (r_state == ST_RUN) && !HALT;
    end

    cycle_counter #(
        .W    (RST_CNT_W),
        .TERM (RST_CNT_W'(RESET_CYCLES - 1))
    ) u_rst_counter (
        .i_clk   (CLOCK),
        .i_clr   (w_clr),
        .i_en    (w_rst_en),
        .o_count (w_unused_rst_count),
        .o_term  (w_rst_term)
    );

    cycle_counter #(
        .W    (CNT_W),
        .TERM (CNT_W'(TIMEOUT_CYCLES - 1))
    ) u_run_counter (
        .i_clk   (CLOCK),
        .i_clr   (w_clr),
        .i_en    (w_run_en),
        .o_count (w_run_count),
        .o_term  (w_run_term)
    );

    // Run-sequencing FSM with registered outputs.
    // RESET parks the FSM in IDLE; with AUTO_START the following edge enters
    // RST, which gives the RESET_CYCLES+1 edge release latency.
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            r_state     <= ST_IDLE;
            r_cpu_reset <= 1'b1;
            r_running   <= 1'b0;
            r_done      <= 1'b0;
            r_timed_out <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (AUTO_START || START) begin
                        r_state     <= ST_RST;
                        r_cpu_reset <= 1'b1;
                    end
                end
                ST_RST: begin
                    if (w_rst_term) begin
                        r_state     <= ST_RUN;
                        r_cpu_reset <= 1'b0;
                        r_running   <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (HALT) begin
                        r_state     <= ST_DONE;
                        r_cpu_reset <= HOLD_ON_DONE;
                        r_running   <= 1'b0;
                        r_done      <= 1'b1;
                        r_timed_out <= 1'b0;
                    end else if (w_run_term) begin
                        r_state     <= ST_TIMEOUT;
                        r_cpu_reset <= HOLD_ON_DONE;
                        r_running   <= 1'b0;
                        r_done      <= 1'b1;
                        r_timed_out <= 1'b1;
                    end
                end
                ST_DONE, ST_TIMEOUT: begin
                    if (START) begin
                        r_state     <= ST_RST;
                        r_cpu_reset <= 1'b1;
                        r_running   <= 1'b0;
                        r_done      <= 1'b0;
                        r_timed_out <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_cpu_reset <= 1'b1;
                    r_running   <= 1'b0;
                    r_done      <= 1'b0;
                    r_timed_out <= 1'b0;
                end
            endcase
        end
    end

    assign CPU_RESET = r_cpu_reset;
    assign RUNNING   = r_running;
    assign DONE      = r_done;
    assign TIMED_OUT = r_timed_out;
    assign CYCLES    = w_run_count;

endmodule

// File: tb/tb_run_controller.sv
// Bench for run_controller: two instances (default parameters, and a small
// AUTO_START=0 / HOLD_ON_DONE=1 variant) checked against a behavioural model,
// plus a vector table and hand-written corner-case sequences.
module tb_run_controller;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance A: defaults
    logic        a_rst = 1'b1, a_start = 1'b0, a_halt = 1'b0;
    logic        a_cpu_reset, a_running, a_done, a_to;
    logic [15:0] a_cycles;

    // Instance B: RESET_CYCLES=3, TIMEOUT_CYCLES=5, CNT_W=3, AUTO_START=0, HOLD_ON_DONE=1
    logic        b_rst = 1'b1, b_start = 1'b0, b_halt = 1'b0;
    logic        b_cpu_reset, b_running, b_done, b_to;
    logic [2:0]  b_cycles;

    run_controller #(
        .RESET_CYCLES   (10),
        .TIMEOUT_CYCLES (1040),
        .CNT_W          (16),
        .AUTO_START     (1'b1),
        .HOLD_ON_DONE   (1'b0)
    ) u_a (
        .CLOCK     (clk),
        .RESET     (a_rst),
        .START     (a_start),
        .HALT      (a_halt),
        .CPU_RESET (a_cpu_reset),
        .RUNNING   (a_running),
        .DONE      (a_done),
        .TIMED_OUT (a_to),
        .CYCLES    (a_cycles)
    );

    run_controller #(
        .RESET_CYCLES   (3),
        .TIMEOUT_CYCLES (5),
        .CNT_W          (3),
        .AUTO_START     (1'b0),
        .HOLD_ON_DONE   (1'b1)
    ) u_b (
        .CLOCK     (clk),
        .RESET     (b_rst),
        .START     (b_start),
        .HALT      (b_halt),
        .CPU_RESET (b_cpu_reset),
        .RUNNING   (b_running),
        .DONE      (b_done),
        .TIMED_OUT (b_to),
        .CYCLES    (b_cycles)
    );

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    task automatic check(input string name, input int unsigned act, input int unsigned exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Phase of the run, a countdown of remaining reset-phase edges, and the
    // number of RUN cycles counted so far.
    localparam int unsigned M_IDLE = 0, M_RST = 1, M_RUN = 2, M_DONE = 3, M_TO = 4;

    int unsigned m_ph[2]    = '{M_IDLE, M_IDLE};
    int unsigned m_rleft[2] = '{0, 0};
    int unsigned m_cyc[2]   = '{0, 0};
    int unsigned p_r[2]     = '{10, 3};
    int unsigned p_t[2]     = '{1040, 5};
    bit          p_auto[2]  = '{1'b1, 1'b0};
    bit          p_hold[2]  = '{1'b0, 1'b1};

    task automatic model_step(input int d, input logic rs, input logic st, input logic hl);
        if (rs) begin
            m_ph[d]  = M_IDLE;
            m_cyc[d] = 0;
        end else begin
            case (m_ph[d])
                M_IDLE: if (p_auto[d] || st) begin
                    m_ph[d] = M_RST; m_rleft[d] = p_r[d]; m_cyc[d] = 0;
                end
                M_RST: begin
                    m_rleft[d] = m_rleft[d] - 1;
                    if (m_rleft[d] == 0) m_ph[d] = M_RUN;
                end
                M_RUN: begin
                    if (hl) m_ph[d] = M_DONE;
                    else begin
                        m_cyc[d] = m_cyc[d] + 1;
                        if (m_cyc[d] == p_t[d]) m_ph[d] = M_TO;
                    end
                end
                default: if (st) begin
                    m_ph[d] = M_RST; m_rleft[d] = p_r[d]; m_cyc[d] = 0;
                end
            endcase
        end
    endtask

    // Expected {CPU_RESET, RUNNING, DONE, TIMED_OUT}
    function automatic int unsigned exp_ctl(input int d);
        bit ended, cr;
        ended = (m_ph[d] == M_DONE) || (m_ph[d] == M_TO);
        cr    = (m_ph[d] == M_IDLE) || (m_ph[d] == M_RST) || (ended && p_hold[d]);
        return {28'd0, cr, (m_ph[d] == M_RUN), ended, (m_ph[d] == M_TO)};
    endfunction

    task automatic tick();
        @(posedge clk);
        model_step(0, a_rst, a_start, a_halt);
        model_step(1, b_rst, b_start, b_halt);
        #1;
        check("modelA_ctl",    32'({a_cpu_reset, a_running, a_done, a_to}), exp_ctl(0));
        check("modelA_cycles", 32'(a_cycles), m_cyc[0]);
        check("modelB_ctl",    32'({b_cpu_reset, b_running, b_done, b_to}), exp_ctl(1));
        check("modelB_cycles", 32'(b_cycles), m_cyc[1]);
    endtask

    // ---------------- vector table for instance B ----------------
    typedef struct {
        logic        rs, st, hl;
        logic [3:0]  ctl;   // {CPU_RESET, RUNNING, DONE, TIMED_OUT}
        int unsigned cyc;
    } vec_t;

    vec_t tbl[32];

    function automatic vec_t mk(input logic rs, input logic st, input logic hl,
                                input logic [3:0] ctl, input int unsigned cyc);
        vec_t v;
        v.rs = rs; v.st = st; v.hl = hl; v.ctl = ctl; v.cyc = cyc;
        return v;
    endfunction

    initial begin
        int unsigned n;

        tbl[0]  = mk(1, 0, 0, 4'b1000, 0);
        tbl[1]  = mk(1, 0, 0, 4'b1000, 0);
        tbl[2]  = mk(0, 0, 0, 4'b1000, 0);  // IDLE waits for START
        tbl[3]  = mk(0, 1, 0, 4'b1000, 0);  // START -> RST
        tbl[4]  = mk(0, 0, 0, 4'b1000, 0);
        tbl[5]  = mk(0, 1, 1, 4'b1000, 0);  // START/HALT ignored in RST
        tbl[6]  = mk(0, 0, 0, 4'b0100, 0);  // third RST edge -> RUN
        tbl[7]  = mk(0, 0, 0, 4'b0100, 1);
        tbl[8]  = mk(0, 1, 0, 4'b0100, 2);  // START ignored in RUN
        tbl[9]  = mk(0, 0, 0, 4'b0100, 3);
        tbl[10] = mk(0, 0, 0, 4'b0100, 4);
        tbl[11] = mk(0, 0, 0, 4'b1011, 5);  // timeout, CPU held
        tbl[12] = mk(0, 0, 1, 4'b1011, 5);
        tbl[13] = mk(0, 1, 0, 4'b1000, 0);  // restart from TIMEOUT
        tbl[14] = mk(0, 0, 0, 4'b1000, 0);
        tbl[15] = mk(0, 0, 1, 4'b1000, 0);
        tbl[16] = mk(0, 0, 0, 4'b0100, 0);
        tbl[17] = mk(0, 0, 0, 4'b0100, 1);
        tbl[18] = mk(0, 0, 0, 4'b0100, 2);
        tbl[19] = mk(0, 0, 0, 4'b0100, 3);
        tbl[20] = mk(0, 0, 0, 4'b0100, 4);
        tbl[21] = mk(0, 0, 1, 4'b1010, 4);  // HALT on the timeout edge wins
        tbl[22] = mk(0, 0, 0, 4'b1010, 4);
        tbl[23] = mk(0, 0, 1, 4'b1010, 4);
        tbl[24] = mk(1, 1, 0, 4'b1000, 0);  // RESET beats START
        tbl[25] = mk(0, 1, 0, 4'b1000, 0);
        tbl[26] = mk(0, 0, 0, 4'b1000, 0);
        tbl[27] = mk(0, 0, 0, 4'b1000, 0);
        tbl[28] = mk(0, 0, 0, 4'b0100, 0);
        tbl[29] = mk(0, 0, 0, 4'b0100, 1);
        tbl[30] = mk(1, 0, 0, 4'b1000, 0);  // RESET mid-run
        tbl[31] = mk(0, 0, 0, 4'b1000, 0);

        // ---- A: reset and release latency ----
        a_rst = 1'b1;
        repeat (10) tick();
        check("A_reset_vals", 32'({a_cpu_reset, a_running, a_done, a_to}), 32'b1000);
        check("A_reset_cycles", 32'(a_cycles), 0);
        a_rst = 1'b0;
        n = 0;
        do begin tick(); n++; end while (a_cpu_reset && n < 40);
        check("A_release_latency", n, 11);
        check("A_running", 32'(a_running), 1);

        // ---- A: full timeout ----
        n = 0;
        do begin tick(); n++; end while (!a_done && n < 1100);
        check("A_timeout_edges", n, 1040);
        check("A_timeout_ctl", 32'({a_cpu_reset, a_running, a_done, a_to}), 32'b0011);
        check("A_timeout_cycles", 32'(a_cycles), 1040);

        // ---- A: restart, then HALT on the 300th RUN edge ----
        a_start = 1'b1; tick(); a_start = 1'b0;
        check("A_restart_ctl", 32'({a_cpu_reset, a_done}), 32'b10);
        check("A_restart_cycles", 32'(a_cycles), 0);
        n = 0;
        do begin tick(); n++; end while (a_cpu_reset && n < 40);
        check("A_restart_rst_edges", n, 10);
        repeat (299) tick();
        a_halt = 1'b1; tick();
        check("A_halt300_ctl", 32'({a_running, a_done, a_to}), 32'b010);
        check("A_halt300_cycles", 32'(a_cycles), 299);
        for (int i = 0; i < 6; i++) begin a_halt = ~a_halt; tick(); end
        a_halt = 1'b0;
        check("A_halt300_frozen", 32'(a_cycles), 299);

        // ---- A: HALT on the edge where CYCLES==1039 ----
        a_start = 1'b1; tick(); a_start = 1'b0;
        n = 0;
        do begin tick(); n++; end while (!a_running && n < 40);
        repeat (1039) tick();
        check("A_pre_edge_cycles", 32'(a_cycles), 1039);
        a_halt = 1'b1; tick(); a_halt = 1'b0;
        check("A_halt1039_ctl", 32'({a_done, a_to}), 32'b10);
        check("A_halt1039_cycles", 32'(a_cycles), 1039);

        // ---- A: RESET on RUN cycle 500 ----
        a_start = 1'b1; tick(); a_start = 1'b0;
        n = 0;
        do begin tick(); n++; end while (!a_running && n < 40);
        repeat (500) tick();
        a_rst = 1'b1; tick(); a_rst = 1'b0;
        check("A_abort_ctl", 32'({a_cpu_reset, a_running, a_done, a_to}), 32'b1000);
        check("A_abort_cycles", 32'(a_cycles), 0);
        n = 0;
        do begin tick(); n++; end while (a_cpu_reset && n < 40);
        check("A_rerun_latency", n, 11);
        tick();
        check("A_rerun_cycles", 32'(a_cycles), 1);

        // ---- B: vector table ----
        for (int i = 0; i < 32; i++) begin
            b_rst = tbl[i].rs; b_start = tbl[i].st; b_halt = tbl[i].hl;
            tick();
            check($sformatf("tblB_ctl[%0d]", i), 32'({b_cpu_reset, b_running, b_done, b_to}), 32'(tbl[i].ctl));
            check($sformatf("tblB_cycles[%0d]", i), 32'(b_cycles), tbl[i].cyc);
        end
        b_rst = 1'b0; b_start = 1'b0; b_halt = 1'b0;

        // ---- B: waits in IDLE without START ----
        repeat (50) tick();
        check("B_idle50_ctl", 32'({b_cpu_reset, b_running, b_done, b_to}), 32'b1000);

        // ---- randomized traffic on both instances ----
        for (int i = 0; i < 4000; i++) begin
            a_rst   = ($urandom_range(0, 299) == 0);
            a_start = ($urandom_range(0, 49) == 0);
            a_halt  = ($urandom_range(0, 199) == 0);
            b_rst   = ($urandom_range(0, 99) == 0);
            b_start = ($urandom_range(0, 5) == 0);
            b_halt  = ($urandom_range(0, 7) == 0);
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/run_controller.md
Name: run_controller

Overview:
- Synthesizable run-control block that sequences a CPU core through the full run: reset, run, and end-of-run.
- It holds the CPU in reset for a parametrised number of cycles, then releases it, counts execution cycles, and detects HALT or a cycle-budget timeout.
- It exposes DONE, TIMED_OUT and the final cycle count, and supports restart on demand.
- It sits between the board clock/reset and the CPU System.

Parameters:
- RESET_CYCLES, 10, cycles CPU_RESET is held high after entering the reset phase (≥1).
- TIMEOUT_CYCLES, 1040, maximum RUN cycles before timeout (≥1, < 2**CNT_W).
- CNT_W, 16, width of cycle counter and CYCLES output.
- AUTO_START, 1, 1 = begin the reset phase immediately after RESET; 0 = wait in IDLE for START.
- HOLD_ON_DONE, 0, 1 = reassert CPU_RESET in DONE/TIMEOUT; 0 = leave CPU released.

Ports:
- CLOCK  input  1  system clock; all logic on the rising edge.
- RESET  input  1  synchronous, active-high block reset.
- START  input  1  single-cycle request to (re)start a run.
- HALT  input  1  halt indication from the CPU.
- CPU_RESET  output  1  reset to the CPU, registered.
- RUNNING  output  1  high while in RUN, registered.
- DONE  output  1  high in DONE or TIMEOUT, registered.
- TIMED_OUT  output  1  high in TIMEOUT only, registered.
- CYCLES  output  CNT_W  RUN cycles counted, registered.

Behaviour:
- Reset values: CPU_RESET=1, RUNNING=0, DONE=0, TIMED_OUT=0, CYCLES=0, internal reset counter=0.
  - Next state is RST if AUTO_START=1, else IDLE.
  - RESET has priority over all other inputs.
  - Asserting RESET mid-run aborts the run and returns to these values on the next edge.
- States: IDLE, RST, RUN, DONE, TIMEOUT.
- IDLE:
  - CPU_RESET=1; all status low; CYCLES holds its last value.
  - START=1 → RST, with the reset counter and CYCLES cleared.
- RST:
  - CPU_RESET=1; the reset counter increments each cycle.
  - After exactly RESET_CYCLES edges in RST → RUN.
  - The first RUN cycle has CPU_RESET=0 and RUNNING=1.
  - HALT and START are ignored.
- RUN (HALT is sampled on each edge):
  - HALT=1 → DONE; CYCLES is not incremented on that edge.
  - HALT=0 and CYCLES==TIMEOUT_CYCLES-1 → TIMEOUT; CYCLES becomes TIMEOUT_CYCLES.
  - HALT=0 otherwise → CYCLES+1.
  - HALT=1 on the timeout edge: HALT wins (DONE, TIMED_OUT=0).
  - START is ignored in RUN.
- DONE:
  - DONE=1, RUNNING=0, TIMED_OUT=0, CYCLES frozen.
  - CPU_RESET = HOLD_ON_DONE.
  - START → RST, with counters cleared; DONE drops on the same edge.
- TIMEOUT: as DONE, but TIMED_OUT=1. START → RST.
- Simultaneous events:
  - START with RESET: RESET wins.
  - START in IDLE with AUTO_START=1 cannot occur, since reset goes to RST.
- Latency:
  - Reset release to CPU_RESET low: RESET_CYCLES+1 edges (AUTO_START=1), counted from the first edge with RESET=0.
  - HALT to DONE: 1 edge.
- Width rules: the counter is unsigned CNT_W bits. The comparison against TIMEOUT_CYCLES-1 is done at CNT_W width. The counter never wraps, because timeout stops it.

Decomposition:
- Shared package holds the state enum (IDLE, RST, RUN, DONE, TIMEOUT) and a localparam for the reset-counter width, $clog2(RESET_CYCLES+1).
- One natural sub-module: cycle_counter, a CNT_W counter with synchronous clear, enable and terminal-count compare.
  - Instantiated twice: once for the reset phase, once for RUN.

Test Plan:
- Defaults, RESET high 10 cycles, then low, with HALT=0 → CPU_RESET low exactly 11 edges after RESET falls; RUNNING=1.
  - TIMEOUT after 1040 RUN cycles; TIMED_OUT=1, DONE=1, CYCLES=1040.
- HALT raised on the 300th RUN edge → DONE=1, TIMED_OUT=0, CYCLES=299, and CYCLES is stable while HALT toggles afterwards.
- HALT raised exactly on the edge where CYCLES==1039 → DONE=1, TIMED_OUT=0, CYCLES=1039.
- AUTO_START=0: after reset the block stays in IDLE with CPU_RESET=1 for 50 cycles. A START pulse then gives RST for 10 cycles, then RUN.
  - START pulses during RST/RUN have no effect.
- After DONE, a START pulse → CYCLES=0 and DONE=0 on the next edge, CPU_RESET=1 for 10 cycles, then a fresh run.
  - With HOLD_ON_DONE=1, CPU_RESET=1 while in DONE.
- RESET asserted on RUN cycle 500 → all outputs at reset values on the next edge. The run restarts from RST after RESET drops; CYCLES counts from 0.
